// File: rtl/pkt_rr_mux_pkg.sv
// pkt_rr_mux_pkg: FSM state encoding and lowest-set-bit index helper shared by the packet mux
package pkt_rr_mux_pkg;
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
  function automatic int lsb_idx(input logic [31:0] v);
    lsb_idx = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) lsb_idx = i;
  endfunction
endpackage

// File: rtl/pkt_rr_mux_rr_pick.sv
// rr_pick: combinational masked round-robin pick returning one-hot winner, its index and the mask of bits above it
module rr_pick
  import pkt_rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  higher
);
  logic [N-1:0] masked, sel;
  always_comb begin
    masked = req & mask;
    sel    = |masked ? masked : req;
    onehot = sel & (~sel + N'(1));
    idx    = IW'(lsb_idx(32'(sel)));
    higher = ~((onehot << 1) - N'(1));
  end
endmodule

// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: packet-granular round-robin mux sharing one valid/ready stream among NUM_REQ sources
module pkt_rr_mux
  import pkt_rr_mux_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_last,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      pkt_done
);
  state_t state, nxt;
  logic [NUM_REQ-1:0] mask_reg, hi_reg, elig, win_oh, win_hi;
  logic [IDX_W-1:0] win_idx, g;
  logic done_r, act, hs_last;
  assign elig = arb_enable ? in_valid : {{(NUM_REQ-1){1'b0}}, in_valid[0]};
  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req   (elig),
    .mask  (mask_reg),
    .onehot(win_oh),
    .idx   (win_idx),
    .higher(win_hi)
  );
  always_comb begin
    act       = state == LOCK && !rst;
    out_valid = act && in_valid[g];
    out_last  = act && in_last[g];
    out_data  = act ? in_data[g*DATA_W +: DATA_W] : '0;
    in_ready  = act ? NUM_REQ'(out_ready) << g : '0;
    hs_last   = out_valid && out_ready && out_last;
    nxt       = state == IDLE ? (|win_oh ? LOCK : IDLE) : (hs_last ? IDLE : LOCK);
    busy      = act;
    grant_idx = rst ? '0 : g;
    pkt_done  = done_r && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask_reg <= '1;
      hi_reg   <= '0;
      g        <= '0;
      done_r   <= 1'b0;
    end else begin
      state  <= nxt;
      done_r <= hs_last;
      if (state == IDLE && |win_oh) begin
        g      <= win_idx;
        hi_reg <= win_hi;
      end
      if (hs_last) mask_reg <= hi_reg;
    end
  end
endmodule

// File: doc/pkt_rr_mux.md
# pkt_rr_mux

Packet-granular round-robin multiplexer that shares one downstream valid/ready stream between NUM_REQ upstream packet sources. Arbitration happens only at packet boundaries; the granted source keeps the output until its `last` beat is accepted, then the round-robin pointer advances past it. The block sits in front of shared datapath resources (router output port, core input FIFO) where beats of different packets must never interleave.

## Interface
- `NUM_REQ`, 4: number of upstream sources, ≥2.
- `DATA_W`, 64: beat width.
- `IDX_W`, $clog2(NUM_REQ): grant index width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arb_enable`  in  1  1 = round-robin; 0 = only source 0 may be granted.
- `in_valid`  in  NUM_REQ  per-source beat valid.
- `in_last`  in  NUM_REQ  per-source last-beat flag.
- `in_data`  in  NUM_REQ*DATA_W  per-source beat, source i at bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_REQ  per-source ready; at most one bit set.
- `out_valid`  out  1  downstream beat valid.
- `out_last`  out  1  downstream last flag.
- `out_data`  out  DATA_W  downstream beat.
- `out_ready`  in  1  downstream ready.
- `busy`  out  1  1 while a packet is locked.
- `grant_idx`  out  IDX_W  index of the locked source; valid when `busy`=1.
- `pkt_done`  out  1  one-cycle pulse on the cycle after a last beat is accepted.

## Operation
- FSM with two states, IDLE and LOCK.
- IDLE:
  - All `in_ready`=0, `out_valid`=0.
  - If any eligible `in_valid`: register the winner into `grant_idx` and go to LOCK.
  - Eligible set = `in_valid`, or `in_valid[0]` only when `arb_enable`=0.
- Winner selection:
  - `req_masked` = eligible & `mask_reg`.
  - If `req_masked`≠0, take its lowest set bit; otherwise take the lowest set bit of the eligible set.
- LOCK with g=`grant_idx`:
  - `out_valid`=`in_valid[g]`, `out_last`=`in_last[g]`, `out_data`=slice g.
  - `in_ready[g]`=`out_ready`; all other ready bits are 0. This path is combinational.
  - Handshake = `out_valid & out_ready`.
  - Handshake with `out_last`=1: return to IDLE, set `mask_reg` = bits strictly above g (all zero when g=NUM_REQ-1), and pulse `pkt_done` next cycle.
- Once in LOCK, a drop of `in_valid[g]` mid-packet only stalls; the lock is held. No timeout.
- `arb_enable` is sampled only in IDLE. Changing it during LOCK does not break the packet.
- `mask_reg` is updated only at packet completion, never in IDLE.
- A single-beat packet (`last` on the first beat) is legal.

## Timing
- Reset (while `rst`=1 and on the cycle after): state=IDLE, `mask_reg`=all ones, `grant_idx`=0, `busy`=0, `pkt_done`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Arbitration latency: a request seen in IDLE at cycle t means LOCK and the first beat is visible at t+1.
- Each packet costs one bubble cycle. An N-beat packet with constant `out_ready` occupies N+1 cycles.
- Valid/ready to data path: zero-cycle combinational pass-through in LOCK.
- Reset asserted mid-packet: the lock is dropped immediately. Partially transferred packets are the upstream's concern.
- Source g reasserting right after its own packet: it waits until every other pending source has been served once.

## Structure
- Shared package holds:
  - The FSM state enumeration (IDLE=1'b0, LOCK=1'b1).
  - A helper function for the lowest-set-bit one-hot to index conversion.
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: request vector and mask.
  - Outputs: one-hot winner, winner index, and the "higher-than-winner" mask.
  - Instantiated once.
- The top contains the FSM, `mask_reg`, `grant_idx`, the output mux and the `pkt_done` register.

## Test plan
- **Reset mid-packet:** source 3 locked on beat 2 of 4, `rst`=1 for one cycle → next cycle `busy`=0, `in_ready`=0; with `in_valid`=4'b0011, the next grant is source 0.
- **Round-robin fairness:** all 4 sources each send one 3-beat packet continuously with `out_ready`=1 → grant order 0,1,2,3,0; each packet takes 4 cycles; `pkt_done` pulses every 4 cycles.
- **No interleave under stall:** source 1 locked, `in_valid[1]` dropped for 5 cycles while source 2 is valid → `out_valid`=0 and `in_ready[2]`=0 throughout; the packet resumes and completes from source 1.
- **Wrap-around:** after source 3 completes, `in_valid`=4'b1001 → source 0 granted. After source 2 completes, `in_valid`=4'b0101 → source 0 granted.
- **arb_enable=0:** `in_valid`=4'b1110 → stays IDLE, all ready bits 0. Setting `in_valid[0]`=1 → source 0 granted. Clearing `arb_enable` mid-packet of source 2 → that packet completes.
- **Backpressure plus single-beat packet:** `out_ready` toggling 1010… with a 1-beat packet (`last`=1) from source 1 → `in_ready[1]` mirrors `out_ready`, the lock releases on the first accepted beat, and `mask_reg`=4'b1100.
